multi_timer: RTL and testbench

//   Parametrised multi-channel programmable timer. Generalised successor of the single 8-bit

---
 rtl/multi_timer.sv | 145 ++++++++++++++
 tb/tb_multi_timer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Multi-channel programmable timer with a shared prescaler and per-channel one-shot/periodic mode.
// Latency: tick/busy registered (expiry seen one edge after the terminal pre_tick); rd_count 1 cycle after cfg_ch.
// Backpressure: none; strobes are sampled every cycle and ticks are single-cycle pulses with no handshake.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_pre_we/i_pre_value load shared prescaler divisor D (one pre_tick every D+1 clk)
//   i_cfg_we/i_cfg_ch    write period/mode of channel i_cfg_ch; i_cfg_ch also selects readback
//   i_cfg_period         period P (expiry after P+1 pre_ticks)
//   i_cfg_mode           0 = one-shot, 1 = periodic
//   i_start/i_stop       per-channel start(restart)/stop strobes, stop wins
//   o_tick               registered one-cycle expiry pulse per channel
//   o_busy               channel is in RUN
//   o_rd_count           registered count of channel i_cfg_ch
module multi_timer #(
    parameter  int CHANNELS   = 4,
    parameter  int COUNT_W    = 16,
    parameter  int PRESCALE_W = 8,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pre_we,
    input  logic [PRESCALE_W-1:0] i_pre_value,
    input  logic                  i_cfg_we,
    input  logic [CH_W-1:0]       i_cfg_ch,
    input  logic [COUNT_W-1:0]    i_cfg_period,
    input  logic                  i_cfg_mode,
    input  logic [CHANNELS-1:0]   i_start,
    input  logic [CHANNELS-1:0]   i_stop,
    output logic [CHANNELS-1:0]   o_tick,
    output logic [CHANNELS-1:0]   o_busy,
    output logic [COUNT_W-1:0]    o_rd_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Shared prescaler
    logic [PRESCALE_W-1:0] r_pre_d;
    logic [PRESCALE_W-1:0] r_div;
    logic                  w_pre_tick;

    assign w_pre_tick = (r_div == r_pre_d);

    // Free-running divider; only a divisor write re-phases it, never a channel start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_d <= '0;
            r_div   <= '0;
        end else if (i_pre_we) begin
            r_pre_d <= i_pre_value;
            r_div   <= '0;
        end else if (w_pre_tick) begin
            r_div   <= '0;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    // Channel state
    state_t               r_state     [CHANNELS];
    logic [COUNT_W-1:0]   r_cnt       [CHANNELS];
    logic [COUNT_W-1:0]   r_period    [CHANNELS];
    logic [CHANNELS-1:0]  r_mode;
    logic [CHANNELS-1:0]  r_tick;
    logic [COUNT_W-1:0]   r_rd_count;

    state_t               w_nxt_state [CHANNELS];
    logic [COUNT_W-1:0]   w_nxt_cnt   [CHANNELS];
    logic [CHANNELS-1:0]  w_nxt_tick;
    logic [CHANNELS-1:0]  w_busy;

    // Priority per channel: stop > start (restart) > expiry/decrement.
    always_comb begin
        w_nxt_tick = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_nxt_state[c] = r_state[c];
            w_nxt_cnt[c]   = r_cnt[c];
            if (i_stop[c]) begin
                w_nxt_state[c] = S_IDLE;
                w_nxt_cnt[c]   = '0;
            end else if (i_start[c]) begin
                w_nxt_state[c] = S_RUN;
                w_nxt_cnt[c]   = r_period[c];
            end else if (r_state[c] == S_RUN && w_pre_tick) begin
                if (r_cnt[c] != '0) begin
                    w_nxt_cnt[c] = r_cnt[c] - 1'b1;
                end else begin
                    w_nxt_tick[c] = 1'b1;
                    if (r_mode[c]) begin
                        w_nxt_cnt[c] = r_period[c];
                    end else begin
                        w_nxt_state[c] = S_IDLE;
                        w_nxt_cnt[c]   = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c]  <= S_IDLE;
                r_cnt[c]    <= '0;
                r_period[c] <= '0;
            end
            r_mode     <= '0;
            r_tick     <= '0;
            r_rd_count <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= w_nxt_state[c];
                r_cnt[c]   <= w_nxt_cnt[c];
            end
            r_tick <= w_nxt_tick;
            // Readback shows the count held before this edge; out-of-range selects read 0.
            if (int'(i_cfg_ch) < CHANNELS) begin
                r_rd_count <= r_cnt[i_cfg_ch];
            end else begin
                r_rd_count <= '0;
            end
            // Config never touches the live count; it takes effect at the next start/reload.
            if (i_cfg_we && int'(i_cfg_ch) < CHANNELS) begin
                r_period[i_cfg_ch] <= i_cfg_period;
                r_mode[i_cfg_ch]   <= i_cfg_mode;
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_busy[c] = (r_state[c] == S_RUN);
        end
    end

    assign o_tick     = r_tick;
    assign o_busy     = w_busy;
    assign o_rd_count = r_rd_count;

endmodule

// File: tb/tb_multi_timer.sv
// Randomised and directed bench for multi_timer with a scoreboard queue.
// The reference model tracks a global pre_tick index and per-channel expiry targets.
// No backpressure; one expected entry is pushed per clock and popped by the monitor.
module tb_multi_timer;
    localparam int CH = 4;
    localparam int CW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pre_we;
    logic [PW-1:0] i_pre_value;
    logic          i_cfg_we;
    logic [1:0]    i_cfg_ch;
    logic [CW-1:0] i_cfg_period;
    logic          i_cfg_mode;
    logic [CH-1:0] i_start;
    logic [CH-1:0] i_stop;
    logic [CH-1:0] o_tick;
    logic [CH-1:0] o_busy;
    logic [CW-1:0] o_rd_count;

    always #5 clk = ~clk;

    multi_timer #(.CHANNELS(CH), .COUNT_W(CW), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_pre_we    (i_pre_we),
        .i_pre_value (i_pre_value),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_ch    (i_cfg_ch),
        .i_cfg_period(i_cfg_period),
        .i_cfg_mode  (i_cfg_mode),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .o_tick      (o_tick),
        .o_busy      (o_busy),
        .o_rd_count  (o_rd_count)
    );

    typedef struct {
        logic [CH-1:0] tick;
        logic [CH-1:0] busy;
        logic [CW-1:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: pre_ticks are numbered globally; a running channel expires
    // on the pre_tick whose index equals its target, and its visible count is the
    // number of pre_ticks still to go before that one.
    longint m_n;
    longint m_tgt [CH];
    bit     m_run [CH];
    int     m_per [CH];
    bit     m_mode[CH];
    int     m_d    = 0;
    longint m_cyc  = 0;
    longint m_load = 0;

    function automatic void model_push();
        exp_t   e;
        bit     pt;
        longint nn;
        e.tick = '0;
        e.busy = '0;
        e.rd   = '0;
        if (rst) begin
            m_d    = 0;
            m_load = m_cyc + 1;
            m_n    = 0;
            for (int c = 0; c < CH; c++) begin
                m_run[c]  = 1'b0;
                m_per[c]  = 0;
                m_mode[c] = 1'b0;
                m_tgt[c]  = 0;
            end
        end else begin
            if (m_run[i_cfg_ch]) e.rd = CW'(m_tgt[i_cfg_ch] - m_n - 1);
            pt = (((m_cyc - m_load) % longint'(m_d + 1)) == longint'(m_d));
            nn = m_n + (pt ? 1 : 0);
            for (int c = 0; c < CH; c++) begin
                if (i_stop[c]) begin
                    m_run[c] = 1'b0;
                end else if (i_start[c]) begin
                    m_run[c] = 1'b1;
                    m_tgt[c] = nn + m_per[c] + 1;
                end else if (m_run[c] && pt && nn == m_tgt[c]) begin
                    e.tick[c] = 1'b1;
                    if (m_mode[c]) m_tgt[c] = nn + m_per[c] + 1;
                    else           m_run[c] = 1'b0;
                end
            end
            m_n = nn;
            if (i_pre_we) begin
                m_d    = int'(i_pre_value);
                m_load = m_cyc + 1;
            end
            if (i_cfg_we) begin
                m_per[i_cfg_ch]  = int'(i_cfg_period);
                m_mode[i_cfg_ch] = i_cfg_mode;
            end
            for (int c = 0; c < CH; c++) e.busy[c] = m_run[c];
        end
        m_cyc++;
        sb_q.push_back(e);
    endfunction

    // Monitor: every clock the DUT presents tick/busy/rd_count; compare with the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_tick", 32'(o_tick), 32'(e.tick));
            check("sb_busy", 32'(o_busy), 32'(e.busy));
            check("sb_rd_count", 32'(o_rd_count), 32'(e.rd));
        end
    end

    task automatic clr();
        rst          = 1'b0;
        i_pre_we     = 1'b0;
        i_pre_value  = '0;
        i_cfg_we     = 1'b0;
        i_cfg_ch     = '0;
        i_cfg_period = '0;
        i_cfg_mode   = 1'b0;
        i_start      = '0;
        i_stop       = '0;
    endtask

    // Commit the inputs currently driven for one clock edge.
    task automatic nxt();
        model_push();
        @(posedge clk);
        @(negedge clk);
        clr();
    endtask

    task automatic cfg(input int ch, input int p, input bit mode);
        i_cfg_we     = 1'b1;
        i_cfg_ch     = 2'(ch);
        i_cfg_period = CW'(p);
        i_cfg_mode   = mode;
        nxt();
    endtask

    task automatic pre(input int d);
        i_pre_we    = 1'b1;
        i_pre_value = PW'(d);
        nxt();
    endtask

    task automatic rand_inputs(input bit allow_start);
        i_pre_we     = ($urandom_range(0, 63) == 0);
        i_pre_value  = PW'($urandom_range(0, 3));
        i_cfg_we     = ($urandom_range(0, 7) == 0);
        i_cfg_ch     = 2'($urandom_range(0, CH - 1));
        i_cfg_period = CW'($urandom_range(0, 12));
        i_cfg_mode   = 1'($urandom_range(0, 1));
        for (int c = 0; c < CH; c++) begin
            i_start[c] = allow_start && ($urandom_range(0, 15) == 0);
            i_stop[c]  = ($urandom_range(0, 31) == 0);
        end
    endtask

    // Cycles until the next tick on channel ch; -1 if none within bound.
    task automatic wait_tick(input int ch, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            nxt();
            if (o_tick[ch] === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int cnt;

    initial begin
        clr();

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            rand_inputs(1'b1);
            i_start = 4'($urandom_range(0, 15));
            rst = 1'b1;
            nxt();
        end
        check("rst_tick", 32'(o_tick), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_rd_count", 32'(o_rd_count), 32'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            rand_inputs(1'b0);
            nxt();
            if (o_tick != '0) cnt++;
        end
        check("no_tick_without_start", 32'(cnt), 32'd0);

        // One-shot D=0 P=5
        pre(0);
        cfg(0, 5, 1'b0);
        i_start[0] = 1'b1;
        nxt();
        wait_tick(0, 20, n);
        check("oneshot_delay", 32'(n), 32'd6);
        check("oneshot_busy_drop", 32'(o_busy[0]), 32'd0);

        // Periodic with prescaler D=3, P=2 -> 12 clk
        pre(3);
        cfg(1, 2, 1'b1);
        i_start[1] = 1'b1;
        nxt();
        wait_tick(1, 40, n);
        wait_tick(1, 40, n);
        check("prescale_period_a", 32'(n), 32'd12);
        wait_tick(1, 40, n);
        check("prescale_period_b", 32'(n), 32'd12);
        i_stop[1] = 1'b1;
        nxt();
        check("stop_busy", 32'(o_busy[1]), 32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            nxt();
            if (o_tick[1]) cnt++;
        end
        check("stop_no_tick", 32'(cnt), 32'd0);

        // Restart at cnt==0 with pre_tick, then start+stop together
        pre(0);
        cfg(2, 3, 1'b1);
        i_start[2] = 1'b1;
        nxt();
        repeat (3) nxt();
        i_start[2] = 1'b1;
        nxt();
        check("restart_no_tick", 32'(o_tick[2]), 32'd0);
        check("restart_busy", 32'(o_busy[2]), 32'd1);
        wait_tick(2, 20, n);
        check("restart_reload", 32'(n), 32'd4);
        i_start[2] = 1'b1;
        i_stop[2]  = 1'b1;
        nxt();
        check("stop_beats_start", 32'(o_busy[2]), 32'd0);

        // Period rewrite while running
        cfg(3, 4, 1'b1);
        i_start[3] = 1'b1;
        nxt();
        wait_tick(3, 20, n);
        check("cfg_run_first", 32'(n), 32'd5);
        nxt();
        nxt();
        cfg(3, 9, 1'b1);
        wait_tick(3, 20, n);
        check("cfg_run_current", 32'(n + 3), 32'd5);
        wait_tick(3, 20, n);
        check("cfg_run_next", 32'(n), 32'd10);
        i_stop = '1;
        nxt();

        // All channels P=0 periodic, then reset mid-run
        pre(0);
        for (int c = 0; c < CH; c++) cfg(c, 0, 1'b1);
        i_start = '1;
        nxt();
        for (int i = 0; i < 4; i++) begin
            nxt();
            check("all_tick", 32'(o_tick), 32'hF);
        end
        rst = 1'b1;
        nxt();
        check("midrun_rst_tick", 32'(o_tick), 32'h0);
        check("midrun_rst_busy", 32'(o_busy), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(1'b1);
            rst = ($urandom_range(0, 199) == 0);
            nxt();
        end
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
